// File: rtl/uart_phy.sv
// uart_phy: 8N1 UART serializer/deserializer with a ready/valid byte interface
// on each side. The bit period is CLK_DIV clock cycles. The receiver detects
// the start bit on a synchronized falling edge and samples each bit at its
// midpoint.
module uart_phy #(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       uart_txd,
  input  logic       uart_rxd,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // ---------------------------------------------------------------- transmit
  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            txd_q, txd_d;

  // Transmit state registers; the line idles high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  // Transmit next-state: the registered line level is updated on the same
  // edge as each state/bit change, so every bit lasts exactly CLK_DIV cycles.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_ready   = (tx_state_q == TX_IDLE);
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            txd_d    = tx_shift_q[tx_bit_q + 3'd1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign uart_txd = txd_q;

  // ----------------------------------------------------------------- receive
  logic            sync1_q, sync2_q, prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            byte_done;
  logic            accept;

  // Two-flop synchronizer plus a delay flop for falling-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Receive state, holding register and status pulse registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Receive next-state: mid-bit sampling, then hand-off into the holding
  // register. A completion coinciding with an accept replaces the held byte.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    byte_done   = 1'b0;
    accept      = rx_valid_q && rx_ready;
    case (rx_state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (sync2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_bit_d   = '0;
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (sync2_q) begin
            byte_done = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    if (byte_done) begin
      if (!rx_valid_q || accept) begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      rx_valid_d = 1'b0;
    end
  end

  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_phy.sv
// Directed testbench for uart_phy with CLK_DIV = 16: a cycle table for one
// transmitted frame, a table of received frames, and hand-written sequences
// for loopback, glitch, framing error, overrun and mid-frame reset.
module tb_uart_phy;
  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       uart_txd;
  logic       uart_rxd;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rxd_drv;
  logic       loop_en;
  logic       rx_abort;

  assign uart_rxd = loop_en ? uart_txd : rxd_drv;

  always #5 clk = ~clk;

  uart_phy #(.CLK_DIV(DIV)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .uart_txd     (uart_txd),
    .uart_rxd     (uart_rxd),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  int errors = 0;
  int checks = 0;

  // Observer: accepted bytes and status pulse cycles.
  logic [7:0] rxq[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  always @(negedge clk) begin
    if (rstn && rx_valid && rx_ready) rxq.push_back(rx_data);
    if (rx_frame_err) fe_cnt++;
    if (rx_overrun) ov_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame on the rx pin; stops early (line high) when rx_abort is set.
  task automatic drive_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = f[i];
      for (int k = 0; k < DIV; k++) begin
        if (rx_abort) begin
          rxd_drv = 1'b1;
          return;
        end
        step();
      end
    end
  endtask

  // Waits (bounded) for tx_ready, then performs one handshake.
  task automatic send_byte(input logic [7:0] b, output int waited);
    waited = 0;
    while (!tx_ready && waited < 2000) begin
      step();
      waited++;
    end
    if (!tx_ready) check("tx_ready_timeout", 32'(tx_ready), 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  typedef struct {
    int   first;
    int   last;
    logic txd;
    logic rdy;
  } tx_seg_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_fe;
  } rx_vec_t;

  tx_seg_t tx_tab[11];
  rx_vec_t rx_tab[6];
  int q0, fe0, ov0, n;
  logic [9:0] fr;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 0xA5 LSB first: 1,0,1,0,0,1,0,1
    tx_tab[0]  = '{1,   16,  1'b0, 1'b0};
    tx_tab[1]  = '{17,  32,  1'b1, 1'b0};
    tx_tab[2]  = '{33,  48,  1'b0, 1'b0};
    tx_tab[3]  = '{49,  64,  1'b1, 1'b0};
    tx_tab[4]  = '{65,  80,  1'b0, 1'b0};
    tx_tab[5]  = '{81,  96,  1'b0, 1'b0};
    tx_tab[6]  = '{97,  112, 1'b1, 1'b0};
    tx_tab[7]  = '{113, 128, 1'b0, 1'b0};
    tx_tab[8]  = '{129, 144, 1'b1, 1'b0};
    tx_tab[9]  = '{145, 160, 1'b1, 1'b0};
    tx_tab[10] = '{161, 161, 1'b1, 1'b1};

    rx_tab[0] = '{8'h00, 1'b1, 1'b0};
    rx_tab[1] = '{8'hFF, 1'b1, 1'b0};
    rx_tab[2] = '{8'h6B, 1'b1, 1'b0};
    rx_tab[3] = '{8'h80, 1'b1, 1'b0};
    rx_tab[4] = '{8'h01, 1'b1, 1'b0};
    rx_tab[5] = '{8'hC8, 1'b0, 1'b1};

    rstn     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_ready = 1'b1;
    rxd_drv  = 1'b1;
    loop_en  = 1'b0;
    rx_abort = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_frame_err", 32'(rx_frame_err), 32'd0);
    check("rst_overrun", 32'(rx_overrun), 32'd0);
    step();
    rstn = 1'b1;
    repeat (3) step();

    // TX 0xA5 cycle by cycle; tx_valid stays high with other data to show it is ignored mid-frame
    check("tx_ready_before", 32'(tx_ready), 32'd1);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    step();
    tx_data = 8'h00;
    for (int s = 0; s < 11; s++) begin
      for (int c = tx_tab[s].first; c <= tx_tab[s].last; c++) begin
        @(negedge clk);
        check($sformatf("tx_txd_c%0d", c), 32'(uart_txd), 32'(tx_tab[s].txd));
        check($sformatf("tx_ready_c%0d", c), 32'(tx_ready), 32'(tx_tab[s].rdy));
        if (c == 100) tx_valid = 1'b0;
      end
    end
    step();

    // RX table
    for (int v = 0; v < 6; v++) begin
      q0  = rxq.size();
      fe0 = fe_cnt;
      drive_frame(rx_tab[v].data, rx_tab[v].stop);
      rxd_drv = 1'b1;
      repeat (4) step();
      check($sformatf("rxtab%0d_count", v), 32'(rxq.size() - q0), rx_tab[v].exp_fe ? 32'd0 : 32'd1);
      if (!rx_tab[v].exp_fe)
        check($sformatf("rxtab%0d_data", v), 32'(rxq[q0]), 32'(rx_tab[v].data));
      check($sformatf("rxtab%0d_fe", v), 32'(fe_cnt - fe0), 32'(rx_tab[v].exp_fe));
    end

    // Loopback, back-to-back
    loop_en = 1'b1;
    q0 = rxq.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    send_byte(8'h3C, n);
    send_byte(8'hC3, n);
    check("lb_backtoback_wait", 32'(n), 32'd160);
    repeat (200) step();
    check("lb_count", 32'(rxq.size() - q0), 32'd2);
    check("lb_byte0", 32'(rxq[q0]), 32'h3C);
    check("lb_byte1", 32'(rxq[q0 + 1]), 32'hC3);
    check("lb_fe", 32'(fe_cnt - fe0), 32'd0);
    check("lb_ov", 32'(ov_cnt - ov0), 32'd0);
    loop_en = 1'b0;
    step();

    // Glitch rejection
    q0 = rxq.size(); fe0 = fe_cnt;
    rxd_drv = 1'b0;
    repeat (4) step();
    rxd_drv = 1'b1;
    repeat (40) step();
    check("glitch_no_valid", 32'(rxq.size() - q0), 32'd0);
    check("glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);
    drive_frame(8'h81, 1'b1);
    repeat (4) step();
    check("glitch_next_count", 32'(rxq.size() - q0), 32'd1);
    check("glitch_next_data", 32'(rxq[q0]), 32'h81);

    // Framing error with the line held low afterwards
    q0 = rxq.size(); fe0 = fe_cnt;
    drive_frame(8'h55, 1'b0);
    repeat (40) step();
    check("fe_pulse", 32'(fe_cnt - fe0), 32'd1);
    check("fe_no_valid", 32'(rxq.size() - q0), 32'd0);
    rxd_drv = 1'b1;
    repeat (200) step();
    check("fe_no_restart_fe", 32'(fe_cnt - fe0), 32'd1);
    check("fe_no_restart_valid", 32'(rxq.size() - q0), 32'd0);
    drive_frame(8'hA7, 1'b1);
    repeat (4) step();
    check("fe_recover_data", 32'(rxq[q0]), 32'hA7);

    // Overrun
    rx_ready = 1'b0;
    ov0 = ov_cnt; q0 = rxq.size();
    drive_frame(8'h11, 1'b1);
    repeat (4) step();
    check("ov_first_valid", 32'(rx_valid), 32'd1);
    check("ov_first_data", 32'(rx_data), 32'h11);
    drive_frame(8'h22, 1'b1);
    repeat (4) step();
    check("ov_pulse", 32'(ov_cnt - ov0), 32'd1);
    check("ov_data_kept", 32'(rx_data), 32'h11);
    check("ov_valid_kept", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    check("ov_accept_cycle_valid", 32'(rx_valid), 32'd1);
    step();
    check("ov_valid_dropped", 32'(rx_valid), 32'd0);
    check("ov_accepted_data", 32'(rxq[q0]), 32'h11);

    // Byte completion in the same cycle as an accept (stop sample 154 cycles after pin start)
    rx_ready = 1'b0;
    drive_frame(8'h33, 1'b1);
    repeat (4) step();
    ov0 = ov_cnt;
    fork
      drive_frame(8'h44, 1'b1);
      begin
        repeat (154) step();
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
      end
    join
    repeat (2) step();
    check("coinc_no_overrun", 32'(ov_cnt - ov0), 32'd0);
    check("coinc_valid", 32'(rx_valid), 32'd1);
    check("coinc_data", 32'(rx_data), 32'h44);

    // Reset mid-frame: pending byte held, TX in bit 3 (0x52 bit3 = 0), RX in bit 5
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      drive_frame(8'h96, 1'b1);
      begin
        repeat (30) step();
        tx_data  = 8'h52;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        repeat (71) step();
        @(negedge clk);
        check("midrst_txd_before", 32'(uart_txd), 32'd0);
        check("midrst_valid_before", 32'(rx_valid), 32'd1);
        #1;
        rstn     = 1'b0;
        rx_abort = 1'b1;
        #1;
        check("midrst_txd", 32'(uart_txd), 32'd1);
        check("midrst_tx_ready", 32'(tx_ready), 32'd1);
        check("midrst_rx_valid", 32'(rx_valid), 32'd0);
        check("midrst_rx_data", 32'(rx_data), 32'd0);
        step();
        rstn = 1'b1;
      end
    join
    rx_abort = 1'b0;
    rxd_drv  = 1'b1;
    rx_ready = 1'b1;
    repeat (200) step();
    check("midrst_no_fe", 32'(fe_cnt - fe0), 32'd0);
    check("midrst_no_ov", 32'(ov_cnt - ov0), 32'd0);

    // Next full TX frame, sampled at bit midpoints
    send_byte(8'h52, n);
    fr = {1'b1, 8'h52, 1'b0};
    repeat (7) step();
    for (int j = 0; j < 10; j++) begin
      check($sformatf("post_tx_bit%0d", j), 32'(uart_txd), 32'(fr[j]));
      repeat (16) step();
    end
    // Next full RX frame
    q0 = rxq.size();
    drive_frame(8'h96, 1'b1);
    repeat (4) step();
    check("post_rx_count", 32'(rxq.size() - q0), 32'd1);
    check("post_rx_data", 32'(rxq[q0]), 32'h96);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
